// File: rtl/multiexp_pnt_scl_streamer_if.sv
// rtl/multiexp_pnt_scl_streamer_if.sv - stream interface carrying point/scalar words
interface if_axi_stream #(
  parameter int DAT_BITS = 381,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 6
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;

  modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
  modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_streamer.sv
// rtl/multiexp_pnt_scl_streamer.sv - replays (scalar, point) records from memory as stream packets, KEY_BITS passes
module multiexp_pnt_scl_streamer #(
  parameter int DAT_BITS   = 381,
  parameter int KEY_BITS   = 381,
  parameter int PNT_WORDS  = 4,
  parameter int ADDR_BITS  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [63:0]          i_num_in,
  input  logic [ADDR_BITS-1:0] i_base_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ADDR_BITS-1:0] o_rd_addr,
  output logic                 o_rd_val,
  input  logic                 i_rd_rdy,
  input  logic [DAT_BITS-1:0]  i_rd_dat,
  input  logic                 i_rd_dat_val,
  if_axi_stream.source         o_pnt_scl_if
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(PNT_WORDS + 1);
  localparam int KW = $clog2(KEY_BITS + 1);
  localparam logic [CW:0]          CREDITS    = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]        FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0]        LAST_W     = WW'(PNT_WORDS);
  localparam logic [KW-1:0]        LAST_K     = KW'(KEY_BITS - 1);
  localparam logic [ADDR_BITS-1:0] REC_STRIDE = ADDR_BITS'(PNT_WORDS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [63:0]          num_q;
  logic [63:0]          rec_q;
  logic [KW-1:0]        pass_q;
  logic [WW-1:0]        word_q;
  logic [ADDR_BITS-1:0] base_q;
  logic [ADDR_BITS-1:0] rec_addr_q;

  logic [CW-1:0]        outstanding_q;
  logic [CW-1:0]        fifo_cnt_q;
  logic [PW-1:0]        fifo_wr_q, fifo_rd_q;
  logic [PW-1:0]        tag_wr_q, tag_rd_q;
  logic [DAT_BITS+1:0]  fifo_mem [FIFO_DEPTH];
  logic [1:0]           tag_mem  [FIFO_DEPTH];

  logic                 out_val_q, out_sop_q, out_eop_q;
  logic [DAT_BITS-1:0]  out_dat_q;

  logic start_ok, rd_fire, last_rec, last_req, credit_ok, drain_ok;
  logic out_load, fifo_pop, fifo_push, bypass;
  logic [1:0] rsp_tag;

  assign start_ok  = (state == IDLE) && i_start;
  assign rd_fire   = o_rd_val && i_rd_rdy;
  assign last_rec  = (rec_q == num_q - 64'd1);
  assign last_req  = (pass_q == LAST_K) && last_rec && (word_q == LAST_W);
  // Reads in flight plus buffered words never exceed the FIFO, so responses always have a home
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < CREDITS;
  assign drain_ok  = (fifo_cnt_q == '0) && (outstanding_q == '0) && !out_val_q;

  assign out_load  = !out_val_q || o_pnt_scl_if.rdy;
  assign fifo_pop  = out_load && (fifo_cnt_q != '0);
  // An empty FIFO lets a response go straight to the output register for 1-cycle latency
  assign bypass    = out_load && (fifo_cnt_q == '0) && i_rd_dat_val;
  assign fifo_push = i_rd_dat_val && !bypass;
  assign rsp_tag   = tag_mem[tag_rd_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = (i_num_in == 64'd0) ? DRAIN : FETCH;
      FETCH:   if (rd_fire && last_req) state_nxt = DRAIN;
      DRAIN:   if (drain_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state != IDLE);
    o_rd_val = (state == FETCH) && credit_ok;
    o_done   = (state == DRAIN) && drain_ok;
  end

  // Address tracks the record base incrementally instead of multiplying r by the record size
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      num_q      <= '0;
      base_q     <= '0;
      rec_addr_q <= '0;
      rec_q      <= '0;
      pass_q     <= '0;
      word_q     <= '0;
    end else if (start_ok) begin
      num_q      <= i_num_in;
      base_q     <= i_base_addr;
      rec_addr_q <= i_base_addr;
      rec_q      <= '0;
      pass_q     <= '0;
      word_q     <= '0;
    end else if (rd_fire) begin
      if (word_q == LAST_W) begin
        word_q <= '0;
        if (last_rec) begin
          rec_q      <= '0;
          rec_addr_q <= base_q;
          pass_q     <= pass_q + 1'b1;
        end else begin
          rec_q      <= rec_q + 64'd1;
          rec_addr_q <= rec_addr_q + REC_STRIDE;
        end
      end else begin
        word_q <= word_q + 1'b1;
      end
    end
  end

  assign o_rd_addr = rec_addr_q + ADDR_BITS'(word_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      outstanding_q <= '0;
    end else begin
      case ({rd_fire, i_rd_dat_val})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      if (rd_fire)      tag_wr_q <= tag_wr_q + 1'b1;
      if (i_rd_dat_val) tag_rd_q <= tag_rd_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rd_fire) tag_mem[tag_wr_q] <= {word_q == '0, word_q == LAST_W};
  end

  always_ff @(posedge i_clk) begin
    if (fifo_push) fifo_mem[fifo_wr_q] <= {rsp_tag, i_rd_dat};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) fifo_wr_q <= fifo_wr_q + 1'b1;
      if (fifo_pop)  fifo_rd_q <= fifo_rd_q + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(fifo_push && !fifo_pop && (fifo_cnt_q == FULL_CNT)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_val_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      out_dat_q <= '0;
    end else if (out_load) begin
      out_val_q <= fifo_pop || bypass;
      if (fifo_pop) begin
        {out_sop_q, out_eop_q, out_dat_q} <= fifo_mem[fifo_rd_q];
      end else if (bypass) begin
        {out_sop_q, out_eop_q, out_dat_q} <= {rsp_tag, i_rd_dat};
      end else begin
        out_sop_q <= 1'b0;
        out_eop_q <= 1'b0;
      end
    end
  end

  assign o_pnt_scl_if.val = out_val_q;
  assign o_pnt_scl_if.sop = out_sop_q;
  assign o_pnt_scl_if.eop = out_eop_q;
  assign o_pnt_scl_if.dat = out_dat_q;
  assign o_pnt_scl_if.err = 1'b0;
  assign o_pnt_scl_if.ctl = '0;
  assign o_pnt_scl_if.mod = '0;
endmodule

// File: tb/tb_multiexp_pnt_scl_streamer.sv
// tb/tb_multiexp_pnt_scl_streamer.sv - randomized bench with a packet-list reference model
module tb_multiexp_pnt_scl_streamer;
  localparam int DAT_BITS   = 48;
  localparam int KEY_BITS   = 4;
  localparam int PNT_WORDS  = 4;
  localparam int ADDR_BITS  = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int PKT        = PNT_WORDS + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [63:0]          num_in = '0;
  logic [ADDR_BITS-1:0] base_addr = '0;
  logic                 busy, done, rd_val;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_rdy = 1'b0;
  logic [DAT_BITS-1:0]  rd_dat = '0;
  logic                 rd_dat_val = 1'b0;

  if_axi_stream #(.DAT_BITS(DAT_BITS)) ps_if ();

  multiexp_pnt_scl_streamer #(
    .DAT_BITS(DAT_BITS), .KEY_BITS(KEY_BITS), .PNT_WORDS(PNT_WORDS),
    .ADDR_BITS(ADDR_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_in(num_in), .i_base_addr(base_addr),
    .o_busy(busy), .o_done(done), .o_rd_addr(rd_addr), .o_rd_val(rd_val), .i_rd_rdy(rd_rdy),
    .i_rd_dat(rd_dat), .i_rd_dat_val(rd_dat_val), .o_pnt_scl_if(ps_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    int                   due;
  } pend_t;

  int total = 0;
  int passed = 0;
  logic [ADDR_BITS-1:0] exp_addr[$];
  pend_t pend[$];
  int req_idx = 0, out_idx = 0, req_cnt = 0, acc_cnt = 0, done_cnt = 0, cyc = 0;
  int rdy_mode = 0, lat_min = 1, lat_max = 1;
  int first_resp = -1, first_val = -1;
  int infl, wcyc;
  logic hold_prev = 1'b0, hold_sop, hold_eop;
  logic [DAT_BITS-1:0] hold_dat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DAT_BITS-1:0] mem_word(input logic [ADDR_BITS-1:0] a);
    return {a[15:0] ^ 16'h5A3C, a};
  endfunction

  // Memory, downstream sink and scoreboard; everything happens on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        rd_rdy = 1'b0;
        rd_dat_val = 1'b0;
        ps_if.rdy = 1'b0;
        hold_prev = 1'b0;
      end else begin
        if (busy) begin
          infl = req_cnt - acc_cnt - (ps_if.val ? 1 : 0);
          chk("credit_bound", 64'(infl <= FIFO_DEPTH), 64'd1);
          if (infl >= FIFO_DEPTH) chk("rd_val_no_credit", 64'(rd_val), 64'd0);
        end
        case (rdy_mode)
          0:       ps_if.rdy = 1'b1;
          1:       ps_if.rdy = 1'($urandom_range(0, 1));
          default: ps_if.rdy = 1'b0;
        endcase
        if (hold_prev) begin
          chk("hold_val", 64'(ps_if.val), 64'd1);
          chk("hold_dat", 64'(ps_if.dat), 64'(hold_dat));
          chk("hold_tag", {62'd0, ps_if.sop, ps_if.eop}, {62'd0, hold_sop, hold_eop});
        end
        if (ps_if.val && first_val < 0) first_val = cyc;
        if (ps_if.val && ps_if.rdy) begin
          if (out_idx < exp_addr.size()) begin
            chk("out_dat", 64'(ps_if.dat), 64'(mem_word(exp_addr[out_idx])));
            chk("out_sop", 64'(ps_if.sop), 64'(out_idx % PKT == 0));
            chk("out_eop", 64'(ps_if.eop), 64'(out_idx % PKT == PKT - 1));
            chk("out_side", 64'({ps_if.err, ps_if.ctl, ps_if.mod}), 64'd0);
          end else begin
            chk("extra_word", 64'(out_idx), 64'(exp_addr.size()));
          end
          out_idx++;
          acc_cnt++;
        end
        hold_prev = ps_if.val && !ps_if.rdy;
        hold_dat  = ps_if.dat;
        hold_sop  = ps_if.sop;
        hold_eop  = ps_if.eop;

        rd_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (rd_val && rd_rdy) begin
          if (req_idx < exp_addr.size()) chk("rd_addr", 64'(rd_addr), 64'(exp_addr[req_idx]));
          else chk("extra_req", 64'(req_idx), 64'(exp_addr.size()));
          pend.push_back('{rd_addr, cyc + int'($urandom_range(lat_min, lat_max))});
          req_idx++;
          req_cnt++;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          rd_dat_val = 1'b1;
          rd_dat = mem_word(pend[0].addr);
          void'(pend.pop_front());
          if (first_resp < 0) first_resp = cyc;
        end else begin
          rd_dat_val = 1'b0;
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: packet p reads record p % n; word w of record r sits at base + r*PKT + w
  task automatic begin_run(input logic [63:0] n, input logic [ADDR_BITS-1:0] b);
    exp_addr.delete();
    for (longint p = 0; p < KEY_BITS * longint'(n); p++)
      for (int w = 0; w < PKT; w++)
        exp_addr.push_back(b + ADDR_BITS'((p % longint'(n)) * PKT + w));
    req_idx = 0; out_idx = 0; req_cnt = 0; acc_cnt = 0; done_cnt = 0;
    first_resp = -1; first_val = -1;
    num_in = n;
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic end_checks(input string name);
    tick();
    tick();
    chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({name, "_words"}, 64'(out_idx), 64'(exp_addr.size()));
    chk({name, "_reqs"}, 64'(req_idx), 64'(exp_addr.size()));
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_rd_val"}, 64'(rd_val), 64'd0);
    chk({name, "_val"}, 64'(ps_if.val), 64'd0);
    chk({name, "_sop_eop"}, {62'd0, ps_if.sop, ps_if.eop}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    begin_run(64'd3, 32'h100);
    chk("model_size", 64'(exp_addr.size()), 64'd60);
    chk("model_a0", 64'(exp_addr[0]), 64'h100);
    chk("model_a5", 64'(exp_addr[5]), 64'h105);
    chk("model_a15", 64'(exp_addr[15]), 64'h100);
    chk("model_a59", 64'(exp_addr[59]), 64'h10E);
    wait_done(3000, wcyc);
    end_checks("run_basic");
    chk("min_latency", 64'(first_val - first_resp), 64'd1);

    rdy_mode = 1; lat_min = 1; lat_max = 8;
    begin_run(64'd3, 32'h100);
    wait_done(3000, wcyc);
    end_checks("run_random");

    begin_run(64'd0, 32'h500);
    wait_done(10, wcyc);
    chk("zero_done_latency", 64'(wcyc <= 3), 64'd1);
    end_checks("run_zero");

    lat_max = 4;
    begin_run(64'd1, 32'h40);
    chk("model1_size", 64'(exp_addr.size()), 64'd20);
    chk("model1_a5", 64'(exp_addr[5]), 64'h40);
    chk("model1_a19", 64'(exp_addr[19]), 64'h44);
    wait_done(3000, wcyc);
    end_checks("run_single");

    lat_max = 8;
    begin_run(64'd3, 32'h200);
    wcyc = 0;
    while (acc_cnt < 33 && wcyc < 3000) begin
      tick();
      wcyc++;
    end
    chk("reach_pass2", 64'(acc_cnt >= 33), 64'd1);
    rst = 1'b1;
    tick();
    check_quiet("mid_reset");
    rst = 1'b0;
    tick();
    begin_run(64'd2, 32'h300);
    wait_done(3000, wcyc);
    end_checks("run_after_reset");

    begin_run(64'd2, 32'h80);
    repeat (5) tick();
    chk("busy_before_restart", 64'(busy), 64'd1);
    num_in = 64'd5;
    base_addr = 32'h900;
    start = 1'b1;
    tick();
    start = 1'b0;
    rdy_mode = 2;
    repeat (100) tick();
    rdy_mode = 1;
    wait_done(3000, wcyc);
    end_checks("run_stall");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
